uart_tx_ctrl: RTL

//  Frame controller for the UART transmitter; sits beside the 8-bit serializer.

---
 rtl/uart_tx_pkg.sv | 16 +
 rtl/uart_parity_calc.sv | 15 +
 rtl/uart_tx_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: FSM encodings, parity
// selectors and the default frame data width.
package uart_tx_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator; shared between the TX frame controller
// and the future RX checker.
module uart_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_par_typ,
    output logic                  o_par_bit
);

    assign o_par_bit = (i_par_typ == PAR_ODD) ? ~^i_data : ^i_data;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: sequences start, data, optional parity and
// stop bits, steering the external serializer one bit time per clock.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int STOP_BITS  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic                  ser_en,
    output logic                  Busy,
    output logic                  TX_OUT
);

    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic       r_stop_cnt;
    logic       r_par_en;
    logic       r_par_bit;
    logic       r_busy;
    logic       r_tx;
    logic       w_tx_d;
    logic       w_accept;
    logic       w_par_bit;

    assign w_accept = Data_Valid && !r_busy && (r_state == IDLE);

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .i_data    (P_DATA),
        .i_par_typ (PAR_TYP),
        .o_par_bit (w_par_bit)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Any unlisted encoding falls back to IDLE.
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = w_accept ? START : IDLE;
            START:   w_next = DATA;
            DATA:    w_next = ser_done ? (r_par_en ? PARITY : STOP) : DATA;
            PARITY:  w_next = STOP;
            STOP:    w_next = (r_stop_cnt == LAST_STOP) ? IDLE : STOP;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        ser_en = 1'b0;
        w_tx_d = 1'b1;
        case (r_state)
            START:   w_tx_d = 1'b0;
            DATA: begin
                ser_en = 1'b1;
                w_tx_d = ser_data;
            end
            PARITY:  w_tx_d = r_par_bit;
            default: w_tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_stop_cnt <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_busy     <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_stop_cnt <= (r_state == STOP) ? r_stop_cnt + 1'b1 : 1'b0;
            if (w_accept) begin
                r_par_en  <= PAR_EN;
                r_par_bit <= w_par_bit;
            end
            // Busy follows the state being entered so it rises on START and falls on IDLE.
            r_busy <= (w_next != IDLE);
            r_tx   <= w_tx_d;
        end
    end

    assign Busy   = r_busy;
    assign TX_OUT = r_tx;

endmodule
